// File: rtl/isa_pkg.sv
// Instruction-set constants shared by the image writer and the decode path:
// opcodes, kind codes, field positions and the field-to-word encoder.
package isa_pkg;

    localparam logic [3:0] OP_R  = 4'b0001;
    localparam logic [3:0] OP_I  = 4'b0010;
    localparam logic [3:0] OP_BR = 4'b1000;
    localparam logic [3:0] OP_J  = 4'b0100;
    localparam logic [3:0] OP_LD = 4'b1100;
    localparam logic [3:0] OP_ST = 4'b0011;

    typedef enum logic [2:0] {
        KIND_R  = 3'd0,
        KIND_I  = 3'd1,
        KIND_BR = 3'd2,
        KIND_J  = 3'd3,
        KIND_LD = 3'd4,
        KIND_ST = 3'd5
    } kind_t;

    localparam int WORD_W    = 24;
    localparam int OPC_LSB   = 20;
    localparam int FA_LSB    = 16;
    localparam int FB_LSB    = 12;
    localparam int FC_LSB    = 8;
    localparam int IMM_I_LSB = 4;
    localparam int FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic kind_legal(input logic [2:0] kind);
        return kind <= 3'd5;
    endfunction

    // Field A/B carry rd/rs, rs/rt or rt/base depending on the kind.
    function automatic logic [WORD_W-1:0] encode(input logic [2:0]  kind,
                                                 input logic [3:0]  ra,
                                                 input logic [3:0]  rb,
                                                 input logic [3:0]  rc,
                                                 input logic [3:0]  funct,
                                                 input logic [19:0] imm);
        logic [WORD_W-1:0] w;
        w = '0;
        case (kind_t'(kind))
            KIND_R: begin
                w[OPC_LSB +: 4]   = OP_R;
                w[FA_LSB +: 4]    = ra;
                w[FB_LSB +: 4]    = rb;
                w[FC_LSB +: 4]    = rc;
                w[FUNCT_LSB +: 4] = funct;
            end
            KIND_I: begin
                w[OPC_LSB +: 4]   = OP_I;
                w[FA_LSB +: 4]    = ra;
                w[FB_LSB +: 4]    = rb;
                w[IMM_I_LSB +: 8] = imm[7:0];
                w[FUNCT_LSB +: 4] = funct;
            end
            KIND_BR: begin
                w[OPC_LSB +: 4] = OP_BR;
                w[FA_LSB +: 4]  = ra;
                w[FB_LSB +: 4]  = rb;
                w[11:0]         = imm[11:0];
            end
            KIND_J: begin
                w[OPC_LSB +: 4] = OP_J;
                w[19:0]         = imm;
            end
            KIND_LD, KIND_ST: begin
                w[OPC_LSB +: 4] = (kind_t'(kind) == KIND_LD) ? OP_LD : OP_ST;
                w[FA_LSB +: 4]  = ra;
                w[FB_LSB +: 4]  = rb;
                w[11:0]         = imm[11:0];
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_image_writer_if.sv
// Field-bundle input handshake and instruction-memory write port of the
// image writer; slave is the writer's view, master the producer/memory view.
interface instr_image_writer_if #(
    parameter int AW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_kind;
    logic [3:0]    in_ra;
    logic [3:0]    in_rb;
    logic [3:0]    in_rc;
    logic [3:0]    in_funct;
    logic [19:0]   in_imm;
    logic          in_last;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic          mem_ready;

    modport slave (
        input  in_valid, in_kind, in_ra, in_rb, in_rc, in_funct, in_imm, in_last,
        output in_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_ready
    );

    modport master (
        output in_valid, in_kind, in_ra, in_rb, in_rc, in_funct, in_imm, in_last,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; exposes the head and the entry
// behind it so the consumer can preload its next output word.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [WIDTH-1:0]       head_next,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [PW-1:0]    rd_idx_next;

    assign level       = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (level == (PW+1)'(DEPTH));
    assign rd_idx_next = rd_ptr[PW-1:0] + 1'b1;
    assign head        = mem[rd_ptr[PW-1:0]];
    assign head_next   = mem[rd_idx_next];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_image_writer.sv
// Packs instruction field bundles into 24-bit words and writes them to
// consecutive instruction-memory addresses through a small FIFO.
module instr_image_writer
    import isa_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        start_addr,
    instr_image_writer_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AW:0]          count
);
    localparam int LW = $clog2(DEPTH) + 1;

    state_t            state, state_nxt;
    logic              accept, legal, push, pop;
    logic              fifo_full, fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic [WORD_W-1:0] enc_word, fifo_head, fifo_head_next, head_data;
    logic              head_vld;

    logic              mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;

    assign bus.in_ready = (state == ST_RUN) && !fifo_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign legal        = kind_legal(bus.in_kind);
    assign push         = accept && legal;
    assign pop          = mem_we_q && bus.mem_ready;
    assign enc_word     = encode(bus.in_kind, bus.in_ra, bus.in_rb, bus.in_rc,
                                 bus.in_funct, bus.in_imm);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wdata     (enc_word),
        .pop       (pop),
        .head      (fifo_head),
        .head_next (fifo_head_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (accept && bus.in_last)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (fifo_empty && !mem_we_q)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The write registers always mirror the FIFO head as it will be after this
    // edge, which gives one-cycle accept-to-write latency and full throughput.
    always_comb begin
        head_vld  = 1'b0;
        head_data = fifo_head;
        if (pop) begin
            if (fifo_level > LW'(1)) begin
                head_vld  = 1'b1;
                head_data = fifo_head_next;
            end else if (push) begin
                head_vld  = 1'b1;
                head_data = enc_word;
            end
        end else if (!fifo_empty) begin
            head_vld  = 1'b1;
            head_data = fifo_head;
        end else if (push) begin
            head_vld  = 1'b1;
            head_data = enc_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count       <= '0;
            err         <= 1'b0;
        end else begin
            mem_we_q <= head_vld;
            if (head_vld)
                mem_wdata_q <= head_data;
            if (state == ST_IDLE && start) begin
                mem_addr_q <= start_addr;
                count      <= '0;
                err        <= 1'b0;
            end else begin
                if (pop) begin
                    mem_addr_q <= mem_addr_q + 1'b1;
                    if (count != '1)
                        count <= count + 1'b1;
                end
                if (accept && !legal)
                    err <= 1'b1;
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_instr_image_writer.sv
// Scoreboard bench for instr_image_writer: accepted bundles are encoded by a
// reference model into an expected-write queue that a monitor drains.
module tb_instr_image_writer;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          busy, done, err;
    logic [AW:0]   count;

    instr_image_writer_if #(.AW(AW)) bus ();

    instr_image_writer #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    always #5 clk = ~clk;

    int            n_total = 0;
    int            n_pass  = 0;
    int            cyc     = 0;
    wr_t           exp_q[$];
    int            wr_cyc_q[$];
    logic [23:0]   wr_data_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [AW-1:0] model_addr;
    logic          model_err;
    int            exp_count;
    int            sess_accepts;
    int            last_acc_cyc;
    bit            rand_ready = 1'b0;
    bit            stalled    = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [23:0]   hold_data;
    wr_t           mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: no response within the cycle budget (t=%0t)", name, $time);
    endtask

    // Word layout computed directly from the instruction format table.
    function automatic logic [23:0] ref_word(int kind, int ra, int rb, int rc, int funct, int imm);
        int w;
        case (kind)
            0:       w = (1  << 20) | (ra << 16) | (rb << 12) | (rc << 8) | funct;
            1:       w = (2  << 20) | (ra << 16) | (rb << 12) | ((imm & 'hFF) << 4) | funct;
            2:       w = (8  << 20) | (ra << 16) | (rb << 12) | (imm & 'hFFF);
            3:       w = (4  << 20) | (imm & 'hFFFFF);
            4:       w = (12 << 20) | (ra << 16) | (rb << 12) | (imm & 'hFFF);
            5:       w = (3  << 20) | (ra << 16) | (rb << 12) | (imm & 'hFFF);
            default: w = 0;
        endcase
        return 24'(w);
    endfunction

    // Monitor: every completed write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.mem_we) begin
            if (bus.mem_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(bus.mem_wdata), 32'(mon_e.data));
                end
                wr_cyc_q.push_back(cyc);
                wr_data_q.push_back(bus.mem_wdata);
                wr_addr_q.push_back(bus.mem_addr);
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_addr_stable", 32'(bus.mem_addr), 32'(hold_addr));
                    check("stall_data_stable", 32'(bus.mem_wdata), 32'(hold_data));
                end
                stalled   = 1'b1;
                hold_addr = bus.mem_addr;
                hold_data = bus.mem_wdata;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // All tasks are entered and left one time unit after a rising edge.
    task automatic do_start(input logic [AW-1:0] addr);
        start      = 1'b1;
        start_addr = addr;
        @(posedge clk);
        #1;
        start        = 1'b0;
        model_addr   = addr;
        model_err    = 1'b0;
        exp_count    = 0;
        sess_accepts = 0;
    endtask

    task automatic send(input int kind, input int ra, input int rb, input int rc,
                        input int funct, input int imm, input bit last);
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_kind  = 3'(kind);
        bus.in_ra    = 4'(ra);
        bus.in_rb    = 4'(rb);
        bus.in_rc    = 4'(rc);
        bus.in_funct = 4'(funct);
        bus.in_imm   = 20'(imm);
        bus.in_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) begin
            timeout_fail("send_accept");
            return;
        end
        last_acc_cyc = cyc;
        sess_accepts++;
        if (kind <= 5) begin
            exp_q.push_back('{addr: model_addr, data: ref_word(kind, ra, rb, rc, funct, imm)});
            model_addr = model_addr + 1'b1;
            exp_count++;
        end else begin
            model_err = 1'b1;
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            timeout_fail({tag, "_done"});
            return;
        end
        check({tag, "_count"}, 32'(count), 32'(exp_count));
        check({tag, "_err"}, 32'(err), 32'(model_err));
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cyc_q.delete();
        wr_data_q.delete();
        wr_addr_q.delete();
    endtask

    logic [23:0] wd;
    int          acc0;

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        start_addr    = '0;
        bus.in_valid  = 1'b0;
        bus.in_kind   = '0;
        bus.in_ra     = '0;
        bus.in_rb     = '0;
        bus.in_rc     = '0;
        bus.in_funct  = '0;
        bus.in_imm    = '0;
        bus.in_last   = 1'b0;
        bus.mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single R word.
        clear_logs();
        do_start(8'h10);
        send(0, 3, 1, 2, 1, 0, 1'b1);
        wait_done("single");
        wd = wr_data_q[0];
        check("single_word", 32'(wd), 32'h131201);
        check("single_addr", 32'(wr_addr_q[0]), 32'h10);

        // Six kinds back to back with the memory always ready.
        clear_logs();
        do_start(8'h20);
        send(0, 4, 5, 6, 7, 0, 1'b0);
        acc0 = last_acc_cyc;
        send(1, 2, 3, 0, 9, 'h5A, 1'b0);
        send(2, 1, 2, 0, 0, 'hFFC, 1'b0);
        send(3, 0, 0, 0, 0, 'h12345, 1'b0);
        send(4, 7, 8, 0, 0, 'h123, 1'b0);
        send(5, 9, 10, 0, 0, 'h456, 1'b1);
        wait_done("six");
        check("six_writes", 32'(wr_cyc_q.size()), 32'd6);
        // The write is presented in the cycle right after the accepting edge.
        check("six_latency", 32'(wr_cyc_q[0]), 32'(acc0));
        check("six_throughput", 32'(wr_cyc_q[5] - wr_cyc_q[0]), 32'd5);
        wd = wr_data_q[1];
        check("I_opcode", 32'(wd[23:20]), 32'h2);
        check("I_imm", 32'(wd[11:4]), 32'h5A);
        wd = wr_data_q[2];
        check("BR_opcode", 32'(wd[23:20]), 32'h8);
        check("BR_imm", 32'(wd[11:0]), 32'hFFC);
        wd = wr_data_q[3];
        check("J_word", 32'(wd), 32'h412345);

        // Memory stalled for 10 cycles while 8 bundles are offered.
        clear_logs();
        do_start(8'h40);
        bus.mem_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)), int'($urandom_range(0, 20'hFFFFF)), i == 7);
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("stall_accepts", 32'(sess_accepts), 32'(DEPTH));
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check("stall_no_write", 32'(wr_cyc_q.size()), 32'd0);
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b1;
            end
        join
        wait_done("stall");
        check("stall_writes", 32'(wr_cyc_q.size()), 32'd8);

        // Illegal kind in mid-stream.
        clear_logs();
        do_start(8'h60);
        send(0, 1, 2, 3, 4, 0, 1'b0);
        send(1, 5, 6, 0, 7, 'hAB, 1'b0);
        send(7, 1, 1, 1, 1, 'h1, 1'b0);
        @(negedge clk);
        check("illegal_err_set", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        send(4, 2, 3, 0, 0, 'h10, 1'b0);
        send(5, 4, 5, 0, 0, 'h20, 1'b1);
        wait_done("illegal");
        check("illegal_writes", 32'(wr_cyc_q.size()), 32'd4);
        check("illegal_err_held", 32'(err), 32'd1);

        // Address wrap.
        clear_logs();
        do_start(8'hFE);
        @(negedge clk);
        check("start_clears_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        send(3, 0, 0, 0, 0, 'h11111, 1'b0);
        send(3, 0, 0, 0, 0, 'h22222, 1'b0);
        send(3, 0, 0, 0, 0, 'h33333, 1'b1);
        wait_done("wrap");
        check("wrap_addr2", 32'(wr_addr_q[2]), 32'h00);

        // Reset while draining with two words queued.
        clear_logs();
        do_start(8'h30);
        bus.mem_ready = 1'b0;
        send(0, 1, 1, 1, 1, 0, 1'b0);
        send(0, 2, 2, 2, 2, 0, 1'b1);
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_mem_we", 32'(bus.mem_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        do_start(8'h50);
        send(2, 3, 4, 0, 0, 'h0AB, 1'b1);
        wait_done("after_rst");
        check("after_rst_addr", 32'(wr_addr_q[0]), 32'h50);

        // Randomised sessions with random back-pressure and input gaps.
        for (int s = 0; s < 3; s++) begin
            do_start(AW'($urandom_range(0, 255)));
            rand_ready = 1'b1;
            for (int i = 0; i < 20; i++) begin
                int k;
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
                send(k, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 20'hFFFFF)), i == 19);
            end
            wait_done("random");
            rand_ready = 1'b0;
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b1;
        end

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
